// File: rtl/cdb_pkg.sv
// ============================================================================
// Module : cdb_pkg
// Brief  : Shared widths, tag field layout and helpers for the CDB arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cdb_pkg;

  localparam int TAG_W       = 8;
  localparam int DATA_W      = 32;
  localparam int GRANT_ID_W  = 3;

  localparam int FU_TYPE_MSB = 7;
  localparam int FU_TYPE_LSB = 5;
  localparam int RS_IDX_MSB  = 4;
  localparam int RS_IDX_LSB  = 0;

  localparam logic [TAG_W-1:0] TAG_IDLE = '0;

  function automatic logic tag_is_idle(input logic [TAG_W-1:0] tag);
    return (tag == TAG_IDLE);
  endfunction

  function automatic logic [FU_TYPE_MSB-FU_TYPE_LSB:0] tag_fu_type(input logic [TAG_W-1:0] tag);
    return tag[FU_TYPE_MSB:FU_TYPE_LSB];
  endfunction

  function automatic logic [RS_IDX_MSB-RS_IDX_LSB:0] tag_rs_idx(input logic [TAG_W-1:0] tag);
    return tag[RS_IDX_MSB:RS_IDX_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
// ============================================================================
// Module : cdb_arbiter_if
// Brief  : Result-port handshake and CDB broadcast bundle of the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cdb_arbiter_if
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic                      flush;
  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ-1:0]        in_ready;
  logic [NUM_REQ*TAG_W-1:0]  in_rs_num;
  logic [NUM_REQ*DATA_W-1:0] in_data;
  logic [TAG_W-1:0]          cdb_rs_num;
  logic [DATA_W-1:0]         cdb_data;
  logic [GRANT_ID_W-1:0]     cdb_grant_id;
  logic                      err_zero_tag;

  // Functional units and flush control side.
  modport master (
    output flush, in_valid, in_rs_num, in_data,
    input  in_ready, cdb_rs_num, cdb_data, cdb_grant_id, err_zero_tag
  );

  // Arbiter side.
  modport slave (
    input  flush, in_valid, in_rs_num, in_data,
    output in_ready, cdb_rs_num, cdb_data, cdb_grant_id, err_zero_tag
  );

endinterface

`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first request at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_idx,
  output logic               grant_valid
);

  // Two passes emulate the wrap: ports >= ptr first, then the rest from 0.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req[i] && (3'(i) >= ptr)) begin
        grant[i]    = 1'b1;
        grant_idx   = 3'(i);
        grant_valid = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req[i]) begin
        grant[i]    = 1'b1;
        grant_idx   = 3'(i);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module : cdb_arbiter
// Brief  : One-entry result buffers per FU port, round-robin CDB broadcast.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0]    occ;
  logic [TAG_W-1:0]      tag_q  [NUM_REQ];
  logic [DATA_W-1:0]     data_q [NUM_REQ];
  logic [TAG_W-1:0]      port_tag  [NUM_REQ];
  logic [DATA_W-1:0]     port_data [NUM_REQ];

  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    xfer;
  logic [NUM_REQ-1:0]    zero_xfer;
  logic [2:0]            grant_idx;
  logic                  grant_valid;
  logic [2:0]            rr_ptr;
  logic [2:0]            ptr_next;
  logic [TAG_W-1:0]      sel_tag;
  logic [DATA_W-1:0]     sel_data;

  logic [TAG_W-1:0]      cdb_rs_num;
  logic [DATA_W-1:0]     cdb_data;
  logic [GRANT_ID_W-1:0] cdb_grant_id;
  logic                  err_zero_tag;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req         (occ),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
      assign port_tag[i]  = bus.in_rs_num[i*TAG_W +: TAG_W];
      assign port_data[i] = bus.in_data[i*DATA_W +: DATA_W];
    end
  endgenerate

  // A granted buffer drains this edge, so it can accept a new result now.
  always_comb begin
    ready     = '0;
    xfer      = '0;
    zero_xfer = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i]     = !bus.flush && (!occ[i] || grant[i]);
      xfer[i]      = bus.in_valid[i] && ready[i];
      zero_xfer[i] = xfer[i] && tag_is_idle(port_tag[i]);
    end
  end

  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_tag  = sel_tag  | tag_q[i];
        sel_data = sel_data | data_q[i];
      end
    end
  end

  assign ptr_next = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (bus.flush) begin
      occ <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer[i]) begin
          occ[i]    <= !zero_xfer[i];
          tag_q[i]  <= port_tag[i];
          data_q[i] <= port_data[i];
        end else if (grant[i]) begin
          occ[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_rs_num   <= TAG_IDLE;
      cdb_data     <= '0;
      cdb_grant_id <= '0;
      rr_ptr       <= '0;
      err_zero_tag <= 1'b0;
    end else if (bus.flush) begin
      cdb_rs_num <= TAG_IDLE;
      cdb_data   <= '0;
    end else begin
      if (grant_valid) begin
        cdb_rs_num   <= sel_tag;
        cdb_data     <= sel_data;
        cdb_grant_id <= grant_idx;
        rr_ptr       <= ptr_next;
      end else begin
        cdb_rs_num <= TAG_IDLE;
        cdb_data   <= '0;
      end
      if (|zero_xfer) begin
        err_zero_tag <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = ready;
  assign bus.cdb_rs_num   = cdb_rs_num;
  assign bus.cdb_data     = cdb_data;
  assign bus.cdb_grant_id = cdb_grant_id;
  assign bus.err_zero_tag = err_zero_tag;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module : tb_cdb_arbiter
// Brief  : Vector table plus scoreboard of expected CDB broadcasts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int NVEC    = 21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  cdb_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] tags;
    logic        flush;
    logic        push;
    logic [7:0]  exp_cdb;
    logic [2:0]  exp_id;
    logic [3:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] data;
    logic [2:0]  id;
  } bc_t;

  vec_t tbl [NVEC];
  bc_t  sb [$];
  bc_t  mon_e;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] dat(input logic [7:0] t);
    return {t, ~t, 8'h5A, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] tags, input logic fl);
    bus.in_valid = v;
    bus.flush    = fl;
    for (int p = 0; p < NUM_REQ; p++) begin
      bus.in_rs_num[p*8 +: 8] = tags[p*8 +: 8];
      bus.in_data[p*32 +: 32] = dat(tags[p*8 +: 8]);
    end
  endtask

  task automatic idle();
    drive(4'b0000, 32'h0, 1'b0);
  endtask

  // Every non-idle broadcast must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.cdb_rs_num !== 8'h00) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got tag %h expected no broadcast", bus.cdb_rs_num);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_tag",  {24'h0, bus.cdb_rs_num},  {24'h0, mon_e.tag});
        chk("sb_data", bus.cdb_data,             mon_e.data);
        chk("sb_id",   {29'h0, bus.cdb_grant_id}, {29'h0, mon_e.id});
      end
    end
  end

  initial begin
    bus.in_valid  = '0;
    bus.in_rs_num = '0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;

    // Contention, rr_ptr starting at 0
    tbl[0]  = '{4'b1111, 32'h8362_4120, 1'b0, 1'b1, 8'h00, 3'd0, 4'b1111};
    tbl[1]  = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h00, 3'd0, 4'b0001};
    tbl[2]  = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h20, 3'd0, 4'b0011};
    tbl[3]  = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h41, 3'd1, 4'b0111};
    tbl[4]  = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h62, 3'd2, 4'b1111};
    tbl[5]  = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h83, 3'd3, 4'b1111};
    // Back-to-back on port 3; grant id holds while idle
    tbl[6]  = '{4'b1000, 32'h6100_0000, 1'b0, 1'b1, 8'h00, 3'd3, 4'b1111};
    tbl[7]  = '{4'b1000, 32'h6200_0000, 1'b0, 1'b1, 8'h00, 3'd3, 4'b1111};
    tbl[8]  = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h61, 3'd3, 4'b1111};
    tbl[9]  = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h62, 3'd3, 4'b1111};
    // Fairness: port0 streams, port2 sends once
    tbl[10] = '{4'b0101, 32'h0045_0011, 1'b0, 1'b1, 8'h00, 3'd3, 4'b1111};
    tbl[11] = '{4'b0001, 32'h0000_0012, 1'b0, 1'b1, 8'h00, 3'd3, 4'b1011};
    tbl[12] = '{4'b0001, 32'h0000_0013, 1'b0, 1'b1, 8'h11, 3'd0, 4'b1110};
    tbl[13] = '{4'b0001, 32'h0000_0013, 1'b0, 1'b1, 8'h45, 3'd2, 4'b1111};
    tbl[14] = '{4'b0001, 32'h0000_0014, 1'b0, 1'b1, 8'h12, 3'd0, 4'b1111};
    tbl[15] = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h13, 3'd0, 4'b1111};
    tbl[16] = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h14, 3'd0, 4'b1111};
    // Flush drops buffered ports 0/1 and the offer made during flush
    tbl[17] = '{4'b0011, 32'h0000_2605, 1'b0, 1'b0, 8'h00, 3'd0, 4'b1111};
    tbl[18] = '{4'b0100, 32'h0047_0000, 1'b1, 1'b0, 8'h00, 3'd0, 4'b0000};
    tbl[19] = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h00, 3'd0, 4'b1111};
    tbl[20] = '{4'b0000, 32'h0,         1'b0, 1'b0, 8'h00, 3'd0, 4'b1111};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cdb_rs_num", {24'h0, bus.cdb_rs_num},   32'h0);
    chk("rst_cdb_data",   bus.cdb_data,              32'h0);
    chk("rst_grant_id",   {29'h0, bus.cdb_grant_id}, 32'h0);
    chk("rst_err",        {31'h0, bus.err_zero_tag}, 32'h0);
    chk("rst_in_ready",   {28'h0, bus.in_ready},     32'hF);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < NVEC; r++) begin
      @(posedge clk);
      #1;
      drive(tbl[r].valid, tbl[r].tags, tbl[r].flush);
      if (tbl[r].push) begin
        for (int p = 0; p < NUM_REQ; p++) begin
          if (tbl[r].valid[p] && tbl[r].exp_ready[p])
            sb.push_back('{tbl[r].tags[p*8 +: 8], dat(tbl[r].tags[p*8 +: 8]), 3'(p)});
        end
      end
      @(negedge clk);
      chk($sformatf("vec%0d_cdb", r),   {24'h0, bus.cdb_rs_num},   {24'h0, tbl[r].exp_cdb});
      chk($sformatf("vec%0d_id", r),    {29'h0, bus.cdb_grant_id}, {29'h0, tbl[r].exp_id});
      chk($sformatf("vec%0d_ready", r), {28'h0, bus.in_ready},     {28'h0, tbl[r].exp_ready});
    end

    // Single port 1 transfer, two-cycle latency, one-cycle broadcast
    @(posedge clk);
    #1;
    idle();
    bus.in_valid[1]      = 1'b1;
    bus.in_rs_num[15:8]  = 8'h21;
    bus.in_data[63:32]   = 32'hDEAD_BEEF;
    sb.push_back('{8'h21, 32'hDEAD_BEEF, 3'd1});
    @(negedge clk);
    chk("single_lat0", {24'h0, bus.cdb_rs_num}, 32'h0);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("single_lat1", {24'h0, bus.cdb_rs_num}, 32'h0);
    @(negedge clk);
    chk("single_tag",  {24'h0, bus.cdb_rs_num},   32'h21);
    chk("single_data", bus.cdb_data,              32'hDEAD_BEEF);
    chk("single_id",   {29'h0, bus.cdb_grant_id}, 32'h1);
    @(negedge clk);
    chk("single_after", {24'h0, bus.cdb_rs_num}, 32'h0);
    chk("single_after_data", bus.cdb_data, 32'h0);

    // Zero tag on port 2 is dropped and flags a sticky error
    chk("zero_err_before", {31'h0, bus.err_zero_tag}, 32'h0);
    @(posedge clk);
    #1;
    drive(4'b0100, 32'h0, 1'b0);
    @(negedge clk);
    chk("zero_ready", {31'h0, bus.in_ready[2]}, 32'h1);
    @(posedge clk);
    #1;
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("zero_cdb%0d", k), {24'h0, bus.cdb_rs_num},   32'h0);
      chk($sformatf("zero_err%0d", k), {31'h0, bus.err_zero_tag}, 32'h1);
    end

    // Reset mid-stream: rr_ptr is 2, so port 2 wins first, the rest are lost
    @(posedge clk);
    #1;
    drive(4'b1111, 32'h8463_4221, 1'b0);
    sb.push_back('{8'h63, dat(8'h63), 3'd2});
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("mid_first", {24'h0, bus.cdb_rs_num}, 32'h63);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cdb",  {24'h0, bus.cdb_rs_num},   32'h0);
    chk("mid_rst_data", bus.cdb_data,              32'h0);
    chk("mid_rst_err",  {31'h0, bus.err_zero_tag}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_cdb%0d", k), {24'h0, bus.cdb_rs_num}, 32'h0);
    end
    chk("post_rst_ready", {28'h0, bus.in_ready}, 32'hF);
    chk("sb_drained", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
